an_decode_check: RTL and testbench

Sequential AN-code checker/decoder that sits at the receive end of an AN-coded datapath, after fault-injection points such as `error_insert`. It accepts one 30-bit codeword per handshake and computes the codeword modulo A with a bit-serial restoring divider. A zero residue returns the quotient directly. A nonzero residue is optionally corrected as a single ±2^i arithmetic error, and the codeword is then re-divided. Saturating counters report detected and corrected errors for fault-campaign statistics.

---
 rtl/an_decode_check.sv | 210 +++++++++++++++++++++
 tb/tb_an_decode_check.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/an_decode_check.sv
// rtl/an_decode_check.sv - bit-serial AN-code residue checker with optional single +/-2^i correction
// Optional feature macro: AN_CORRECT_EN (builds the SEARCH/DIV2 correction path)
module an_decode_check #(
    parameter int CW   = 30,
    parameter int A    = 61,
    parameter int AW   = 6,
    parameter int DW   = 25,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW-1:0]   in_cw,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   data_out,
    output logic            err_detect,
    output logic            err_corrected,
    output logic            err_uncorr,
    output logic [CNTW-1:0] detect_cnt,
    output logic [CNTW-1:0] corr_cnt
);
    localparam int          CNT_W = $clog2(CW + 1);
    localparam logic [AW:0] A_EXT = (AW+1)'(A);

    typedef enum logic [2:0] {S_IDLE, S_DIV, S_SEARCH, S_DIV2, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cw;
    logic [CW-1:0]   r_sh;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]   r_rem;
    logic [DW-1:0]   r_quo;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_err_detect;
    logic            r_err_uncorr;
    logic [DW-1:0]   r_data;
    logic [CNTW-1:0] r_detect_cnt;

    logic [AW:0]     w_trial;
    logic            w_qbit;
    logic [AW-1:0]   w_rem_nxt;
    logic [DW-1:0]   w_quo_nxt;

    // One restoring-division step: shift in the next codeword bit, subtract A if it fits.
    always_comb begin
        w_trial   = {r_rem, r_sh[CW-1]};
        w_qbit    = (w_trial >= A_EXT);
        w_rem_nxt = w_qbit ? AW'(w_trial - A_EXT) : w_trial[AW-1:0];
        w_quo_nxt = {r_quo[DW-2:0], w_qbit};
    end

`ifdef AN_CORRECT_EN
    localparam int IDX_W = $clog2(CW);

    logic [AW-1:0]    r_p;
    logic [IDX_W-1:0] r_idx;
    logic             r_err_corr;
    logic [CNTW-1:0]  r_corr_cnt;

    logic [AW:0]      w_p2;
    logic [AW-1:0]    w_p_nxt;
    logic             w_hit_sub;
    logic             w_hit_add;
    logic [CW-1:0]    w_pow;
    logic [CW-1:0]    w_cw_fix;

    // p tracks 2^idx mod A; a residue of +p or -p points at a single error at bit idx.
    always_comb begin
        w_p2      = {r_p, 1'b0};
        w_p_nxt   = (w_p2 >= A_EXT) ? AW'(w_p2 - A_EXT) : w_p2[AW-1:0];
        w_hit_sub = (r_rem == r_p);
        w_hit_add = ({1'b0, r_rem} == (A_EXT - {1'b0, r_p}));
        w_pow     = CW'(1) << r_idx;
        w_cw_fix  = w_hit_sub ? (r_cw - w_pow) : (r_cw + w_pow);
    end

    assign err_corrected = r_err_corr;
    assign corr_cnt      = r_corr_cnt;
`else
    assign err_corrected = 1'b0;
    assign corr_cnt      = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cw         <= '0;
            r_sh         <= '0;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_err_detect <= 1'b0;
            r_err_uncorr <= 1'b0;
            r_data       <= '0;
            r_detect_cnt <= '0;
`ifdef AN_CORRECT_EN
            r_p          <= AW'(1);
            r_idx        <= '0;
            r_err_corr   <= 1'b0;
            r_corr_cnt   <= '0;
`endif
        end else if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_cw         <= in_cw;
                        r_sh         <= in_cw;
                        r_cnt        <= '0;
                        r_rem        <= '0;
                        r_quo        <= '0;
                        r_err_detect <= 1'b0;
                        r_err_uncorr <= 1'b0;
`ifdef AN_CORRECT_EN
                        r_err_corr   <= 1'b0;
`endif
                        r_in_ready   <= 1'b0;
                        r_state      <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (r_cnt != CNT_W'(CW)) begin
                        r_sh  <= r_sh << 1;
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        // Original quotient is the fallback result for every uncorrected outcome.
                        r_data <= r_quo;
                        if (r_rem == '0) begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_err_detect <= 1'b1;
`ifdef AN_CORRECT_EN
                            r_p     <= AW'(1);
                            r_idx   <= '0;
                            r_state <= S_SEARCH;
`else
                            r_err_uncorr <= 1'b1;
                            r_out_valid  <= 1'b1;
                            r_state      <= S_DONE;
`endif
                        end
                    end
                end
`ifdef AN_CORRECT_EN
                S_SEARCH: begin
                    r_p   <= w_p_nxt;
                    r_idx <= r_idx + 1'b1;
                    if (w_hit_sub || w_hit_add) begin
                        r_cw    <= w_cw_fix;
                        r_sh    <= w_cw_fix;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= '0;
                        r_state <= S_DIV2;
                    end else if (r_idx == IDX_W'(CW - 1)) begin
                        r_err_uncorr <= 1'b1;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DIV2: begin
                    r_sh  <= r_sh << 1;
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(CW - 1)) begin
                        if (w_rem_nxt == '0) begin
                            r_err_corr <= 1'b1;
                            r_data     <= w_quo_nxt;
                        end else begin
                            r_err_uncorr <= 1'b1;
                        end
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                        if (r_err_detect && (r_detect_cnt != '1))
                            r_detect_cnt <= r_detect_cnt + 1'b1;
`ifdef AN_CORRECT_EN
                        if (r_err_corr && (r_corr_cnt != '1))
                            r_corr_cnt <= r_corr_cnt + 1'b1;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign data_out   = r_data;
    assign err_detect = r_err_detect;
    assign err_uncorr = r_err_uncorr;
    assign detect_cnt = r_detect_cnt;
endmodule

// File: tb/tb_an_decode_check.sv
// tb/tb_an_decode_check.sv - table-driven and randomized checks of an_decode_check against an arithmetic model
module tb_an_decode_check;
    localparam int CW   = 30;
    localparam int A    = 61;
    localparam int DW   = 25;
    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clk_en = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CW-1:0]   in_cw = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   data_out;
    logic            err_detect;
    logic            err_corrected;
    logic            err_uncorr;
    logic [CNTW-1:0] detect_cnt;
    logic [CNTW-1:0] corr_cnt;

    an_decode_check dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .err_detect(err_detect), .err_corrected(err_corrected), .err_uncorr(err_uncorr),
        .detect_cnt(detect_cnt), .corr_cnt(corr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] cw;
        int            hold;
        int            lat;
        logic [DW-1:0] d;
        logic          det;
        logic          cor;
        logic          unc;
    } vec_t;

    int  n_chk = 0;
    int  n_fail = 0;
    longint exp_det_cnt = 0;
    longint exp_cor_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected result straight from the code's arithmetic: residue, +/-2^i search, re-division.
    function automatic vec_t model(input logic [CW-1:0] cw, input int hold);
        vec_t   v;
        longint c, r, q, p, c2;
        c = longint'(cw);
        r = c % A;
        q = c / A;
        v.cw = cw; v.hold = hold; v.lat = CW + 1; v.d = DW'(q);
        v.det = (r != 0); v.cor = 1'b0; v.unc = 1'b0;
        if (r != 0) begin
`ifdef AN_CORRECT_EN
            v.lat = 2 * CW + 1;
            v.unc = 1'b1;
            for (int i = 0; i < CW; i++) begin
                p = (longint'(1) << i) % A;
                if (r == p || r == A - p) begin
                    c2 = (r == p) ? c - (longint'(1) << i) : c + (longint'(1) << i);
                    c2 = c2 & ((longint'(1) << CW) - 1);
                    v.lat = 2 * CW + i + 2;
                    if (c2 % A == 0) begin
                        v.cor = 1'b1;
                        v.unc = 1'b0;
                        v.d   = DW'(c2 / A);
                    end
                    break;
                end
            end
`else
            v.unc = 1'b1;
`endif
        end
        return v;
    endfunction

    task automatic run(input vec_t v, input bit toggle);
        int lat;
        int guard;
        @(negedge clk);
        clk_en = 1'b1; in_cw = v.cw; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_busy", in_ready, 0);
        lat = 0; guard = 0;
        while (!out_valid && guard < 1000) begin
            if (toggle) clk_en = ~clk_en;
            if (clk_en) lat++;
            @(negedge clk);
            guard++;
        end
        clk_en = 1'b1;
        if (!out_valid) begin
            chk("timeout_out_valid", out_valid, 1);
            return;
        end
        chk("latency", lat, v.lat);
        chk("data_out", data_out, v.d);
        chk("err_detect", err_detect, v.det);
        chk("err_corrected", err_corrected, v.cor);
        chk("err_uncorr", err_uncorr, v.unc);
        chk("in_ready_done", in_ready, 0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_data_out", data_out, v.d);
            chk("hold_flags", {err_detect, err_corrected, err_uncorr}, {v.det, v.cor, v.unc});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (v.det && exp_det_cnt < 65535) exp_det_cnt++;
        if (v.cor && exp_cor_cnt < 65535) exp_cor_cnt++;
        chk("out_valid_after_accept", out_valid, 0);
        chk("in_ready_after_accept", in_ready, 1);
        chk("detect_cnt", detect_cnt, exp_det_cnt);
        chk("corr_cnt", corr_cnt, exp_cor_cnt);
    endtask

    vec_t tbl[7];

    initial begin
        vec_t   v;
        longint base, c;
        int     seen;

`ifdef AN_CORRECT_EN
        tbl[0] = '{cw: 30'd305,        hold: 2,  lat: 31, d: 25'd5,        det: 0, cor: 0, unc: 0};
        tbl[1] = '{cw: 30'd313,        hold: 1,  lat: 65, d: 25'd5,        det: 1, cor: 1, unc: 0};
        tbl[2] = '{cw: 30'd304,        hold: 0,  lat: 62, d: 25'd5,        det: 1, cor: 1, unc: 0};
        tbl[3] = '{cw: 30'h3FFFFFFF,   hold: 1,  lat: 63, d: 25'd17602324, det: 1, cor: 0, unc: 1};
        tbl[4] = '{cw: 30'd311,        hold: 10, lat: 69, d: 25'd3,        det: 1, cor: 1, unc: 0};
`else
        tbl[0] = '{cw: 30'd305,        hold: 2,  lat: 31, d: 25'd5,        det: 0, cor: 0, unc: 0};
        tbl[1] = '{cw: 30'd313,        hold: 1,  lat: 31, d: 25'd5,        det: 1, cor: 0, unc: 1};
        tbl[2] = '{cw: 30'd304,        hold: 0,  lat: 31, d: 25'd4,        det: 1, cor: 0, unc: 1};
        tbl[3] = '{cw: 30'h3FFFFFFF,   hold: 1,  lat: 31, d: 25'd17602324, det: 1, cor: 0, unc: 1};
        tbl[4] = '{cw: 30'd311,        hold: 10, lat: 31, d: 25'd5,        det: 1, cor: 0, unc: 1};
`endif
        tbl[5] = '{cw: 30'd0,          hold: 0,  lat: 31, d: 25'd0,        det: 0, cor: 0, unc: 0};
        tbl[6] = '{cw: 30'd1073741764, hold: 0,  lat: 31, d: 25'd17602324, det: 0, cor: 0, unc: 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_flags", {err_detect, err_corrected, err_uncorr}, 0);
        chk("rst_detect_cnt", detect_cnt, 0);
        chk("rst_corr_cnt", corr_cnt, 0);

        foreach (tbl[i]) run(tbl[i], 1'b0);

        for (int n = 0; n < 40; n++) begin
            base = longint'(A) * longint'($urandom_range(0, 17602324));
            case ($urandom_range(0, 3))
                0: c = base;
                1: c = base ^ (longint'(1) << $urandom_range(0, CW - 1));
                2: c = ($urandom_range(0, 1) == 1) ? base + (longint'(1) << $urandom_range(0, CW - 1))
                                                  : base - (longint'(1) << $urandom_range(0, CW - 1));
                default: c = longint'($urandom);
            endcase
            v = model(CW'(c), $urandom_range(0, 3));
            run(v, 1'b0);
        end

        // Reset in the middle of a division discards the codeword and clears the counters.
        @(negedge clk);
        in_cw = 30'd313; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_det_cnt = 0;
        exp_cor_cnt = 0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_detect_cnt", detect_cnt, 0);
        chk("abort_corr_cnt", corr_cnt, 0);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_output", seen, 0);

        run(model(30'd305, 3), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
